// File: rtl/psram_line_arbiter.sv
// Arbiter for the shared PSRAM line-transfer port: VGA line reads versus MCU line writes.
// Owns the per-direction line counters and base addresses and drives the size/address handshake.
module psram_line_arbiter #(
   parameter int LINE_WIDTH         = 640,
   parameter int LINE_COUNT         = 480,
   parameter int ADDRESS_WIDTH      = 24,
   parameter int SIZE_WIDTH         = 12,
   parameter int WRITE_STARVE_LIMIT = 4,
   parameter int BUSY_TIMEOUT       = 4095
) (
   input  logic                     system_clock,
   input  logic                     reset_n,
   input  logic                     read_request,
   input  logic                     write_request,
   input  logic                     frame_restart,
   output logic                     read_done,
   output logic                     write_done,
   output logic [SIZE_WIDTH-1:0]    mem_output_size,
   output logic [ADDRESS_WIDTH-1:0] mem_output_address,
   output logic [SIZE_WIDTH-1:0]    mem_input_size,
   output logic [ADDRESS_WIDTH-1:0] mem_input_address,
   input  logic                     mem_busy,
   output logic [9:0]               read_line,
   output logic [9:0]               write_line,
   output logic [1:0]               owner,
   output logic                     timeout_error
);

   localparam int TIMER_W  = $clog2(BUSY_TIMEOUT + 1);
   localparam int STARVE_W = $clog2(WRITE_STARVE_LIMIT + 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE_READ,
      WAIT_READ,
      ISSUE_WRITE,
      WAIT_WRITE
   } state_t;

   state_t                   state;
   logic [ADDRESS_WIDTH-1:0] read_base;
   logic [ADDRESS_WIDTH-1:0] write_base;
   logic [STARVE_W-1:0]      starve_count;
   logic                     restart_pending;
   logic [TIMER_W-1:0]       timer;

   logic restart_now;
   logic starved;
   logic grant_read;
   logic grant_write;
   logic timer_expired;
   logic last_read;
   logic last_write;
   logic done_gap;

   // A restart pulse arriving this cycle is honoured as if it were already pending.
   assign restart_now   = restart_pending | frame_restart;
   assign starved       = (starve_count == STARVE_W'(WRITE_STARVE_LIMIT));
   assign grant_read    = read_request && !(write_request && starved);
   assign grant_write   = write_request && !grant_read;
   assign timer_expired = (timer == TIMER_W'(BUSY_TIMEOUT - 1));
   assign last_read     = (read_line == 10'(LINE_COUNT - 1));
   assign last_write    = (write_line == 10'(LINE_COUNT - 1));
   // No grant in the done cycle, so requesters see done before re-arbitration.
   assign done_gap      = read_done | write_done;

   // Handshake: a nonzero size with its address is a request; it is held
   // until mem_busy=1 is sampled, and completion is mem_busy returning to 0.
   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         state              <= IDLE;
         read_done          <= 1'b0;
         write_done         <= 1'b0;
         mem_output_size    <= '0;
         mem_output_address <= '0;
         mem_input_size     <= '0;
         mem_input_address  <= '0;
         read_line          <= '0;
         write_line         <= '0;
         read_base          <= '0;
         write_base         <= '0;
         owner              <= 2'd0;
         timeout_error      <= 1'b0;
         starve_count       <= '0;
         restart_pending    <= 1'b0;
         timer              <= '0;
      end else begin
         read_done  <= 1'b0;
         write_done <= 1'b0;
         if (frame_restart) restart_pending <= 1'b1;

         case (state)
            IDLE: begin
               owner <= 2'd0;
               timer <= '0;
               if (restart_now) begin
                  read_line       <= '0;
                  read_base       <= '0;
                  restart_pending <= 1'b0;
               end
               if (!done_gap) begin
                  if (grant_read) begin
                     state              <= ISSUE_READ;
                     owner              <= 2'd1;
                     mem_output_size    <= SIZE_WIDTH'(LINE_WIDTH);
                     mem_output_address <= restart_now ? '0 : read_base;
                     if (write_request && !starved)
                        starve_count <= starve_count + STARVE_W'(1);
                  end else if (grant_write) begin
                     state             <= ISSUE_WRITE;
                     owner             <= 2'd2;
                     mem_input_size    <= SIZE_WIDTH'(LINE_WIDTH);
                     mem_input_address <= write_base;
                     starve_count      <= '0;
                  end
               end
            end

            ISSUE_READ: begin
               if (mem_busy) begin
                  mem_output_size    <= '0;
                  mem_output_address <= '0;
                  timer              <= '0;
                  state              <= WAIT_READ;
               end else if (timer_expired) begin
                  mem_output_size    <= '0;
                  mem_output_address <= '0;
                  timeout_error      <= 1'b1;
                  owner              <= 2'd0;
                  state              <= IDLE;
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end

            WAIT_READ: begin
               if (!mem_busy) begin
                  read_done <= 1'b1;
                  owner     <= 2'd0;
                  state     <= IDLE;
                  if (restart_now || last_read) begin
                     read_line       <= '0;
                     read_base       <= '0;
                     restart_pending <= 1'b0;
                  end else begin
                     read_line <= read_line + 10'd1;
                     read_base <= read_base + ADDRESS_WIDTH'(LINE_WIDTH);
                  end
               end else if (timer_expired) begin
                  timeout_error <= 1'b1;
                  owner         <= 2'd0;
                  state         <= IDLE;
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end

            ISSUE_WRITE: begin
               if (mem_busy) begin
                  mem_input_size    <= '0;
                  mem_input_address <= '0;
                  timer             <= '0;
                  state             <= WAIT_WRITE;
               end else if (timer_expired) begin
                  mem_input_size    <= '0;
                  mem_input_address <= '0;
                  timeout_error     <= 1'b1;
                  owner             <= 2'd0;
                  state             <= IDLE;
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end

            WAIT_WRITE: begin
               if (!mem_busy) begin
                  write_done <= 1'b1;
                  owner      <= 2'd0;
                  state      <= IDLE;
                  if (last_write) begin
                     write_line <= '0;
                     write_base <= '0;
                  end else begin
                     write_line <= write_line + 10'd1;
                     write_base <= write_base + ADDRESS_WIDTH'(LINE_WIDTH);
                  end
               end else if (timer_expired) begin
                  timeout_error <= 1'b1;
                  owner         <= 2'd0;
                  state         <= IDLE;
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end

            default: begin
               state <= IDLE;
               owner <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psram_line_arbiter.sv
// Bench for psram_line_arbiter: a transaction table plus hand-written restart, timeout and reset sequences.
module tb_psram_line_arbiter;

   logic        system_clock;
   logic        reset_n;
   logic        read_request;
   logic        write_request;
   logic        frame_restart;
   logic        read_done;
   logic        write_done;
   logic [11:0] mem_output_size;
   logic [23:0] mem_output_address;
   logic [11:0] mem_input_size;
   logic [23:0] mem_input_address;
   logic        mem_busy;
   logic [9:0]  read_line;
   logic [9:0]  write_line;
   logic [1:0]  owner;
   logic        timeout_error;

   int tests;
   int fails;
   logic [25:0] exp_q[$];

   typedef struct {
      bit          rd;
      bit          wr;
      int          dly;
      int          len;
      logic [1:0]  own;
      logic [23:0] addr;
      logic [9:0]  rl;
      logic [9:0]  wl;
   } vec_t;

   vec_t vecs[14];

   psram_line_arbiter dut (
      .system_clock       (system_clock),
      .reset_n            (reset_n),
      .read_request       (read_request),
      .write_request      (write_request),
      .frame_restart      (frame_restart),
      .read_done          (read_done),
      .write_done         (write_done),
      .mem_output_size    (mem_output_size),
      .mem_output_address (mem_output_address),
      .mem_input_size     (mem_input_size),
      .mem_input_address  (mem_input_address),
      .mem_busy           (mem_busy),
      .read_line          (read_line),
      .write_line         (write_line),
      .owner              (owner),
      .timeout_error      (timeout_error)
   );

   // clock / reset
   initial begin
      system_clock = 1'b0;
      forever #5 system_clock = ~system_clock;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [11:0] cur_size(input logic [1:0] own);
      return (own == 2'd1) ? mem_output_size : mem_input_size;
   endfunction

   function automatic logic [23:0] cur_addr(input logic [1:0] own);
      return (own == 2'd1) ? mem_output_address : mem_input_address;
   endfunction

   // Memory-controller driver: serves one transaction and checks it against the scoreboard.
   task automatic run_txn(input int dly, input int len, input bit restart_in_wait);
      logic [25:0] exp;
      logic [1:0]  eown;
      int          cnt;
      int          viol;
      cnt = 0;
      while (owner == 2'd0 && cnt < 100) begin
         @(negedge system_clock);
         cnt++;
      end
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
         return;
      end
      exp  = exp_q.pop_front();
      eown = exp[25:24];
      check("grant_owner", 32'(owner), 32'(eown));
      if (owner == 2'd0) return;
      check("grant_addr", 32'(cur_addr(eown)), 32'(exp[23:0]));
      check("grant_size", 32'(cur_size(eown)), 32'd640);
      check("other_size", 32'(cur_size(eown == 2'd1 ? 2'd2 : 2'd1)), 32'd0);
      viol = 0;
      repeat (dly) begin
         @(negedge system_clock);
         if (cur_size(eown) != 12'd640 || cur_addr(eown) != exp[23:0]) viol++;
      end
      check("hold_until_busy", 32'(viol), 32'd0);
      mem_busy = 1'b1;
      @(negedge system_clock);
      check("size_clear", 32'(cur_size(eown)), 32'd0);
      check("addr_clear", 32'(cur_addr(eown)), 32'd0);
      check("owner_in_wait", 32'(owner), 32'(eown));
      for (int i = 0; i < len; i++) begin
         if (i == 0 && restart_in_wait) frame_restart = 1'b1;
         @(negedge system_clock);
         frame_restart = 1'b0;
      end
      mem_busy = 1'b0;
      @(negedge system_clock);
      check("done_pulse", 32'({read_done, write_done}), (eown == 2'd1) ? 32'd2 : 32'd1);
      check("owner_after_done", 32'(owner), 32'd0);
      @(negedge system_clock);
      check("done_single", 32'({read_done, write_done}), 32'd0);
   endtask

   initial begin
      int          cnt;
      int          wdone;
      logic [23:0] ea;
      tests = 0;
      fails = 0;
      vecs[0]  = '{1, 0, 2, 10, 2'd1, 24'd0,    10'd1,  10'd0};
      vecs[1]  = '{1, 0, 1, 3,  2'd1, 24'd640,  10'd2,  10'd0};
      vecs[2]  = '{1, 1, 1, 3,  2'd1, 24'd1280, 10'd3,  10'd0};
      vecs[3]  = '{1, 1, 0, 4,  2'd1, 24'd1920, 10'd4,  10'd0};
      vecs[4]  = '{1, 1, 1, 3,  2'd1, 24'd2560, 10'd5,  10'd0};
      vecs[5]  = '{1, 1, 2, 2,  2'd1, 24'd3200, 10'd6,  10'd0};
      vecs[6]  = '{1, 1, 1, 3,  2'd2, 24'd0,    10'd6,  10'd1};
      vecs[7]  = '{1, 1, 1, 3,  2'd1, 24'd3840, 10'd7,  10'd1};
      vecs[8]  = '{1, 1, 1, 3,  2'd1, 24'd4480, 10'd8,  10'd1};
      vecs[9]  = '{1, 1, 1, 3,  2'd1, 24'd5120, 10'd9,  10'd1};
      vecs[10] = '{1, 1, 1, 3,  2'd1, 24'd5760, 10'd10, 10'd1};
      vecs[11] = '{1, 1, 1, 3,  2'd2, 24'd640,  10'd10, 10'd2};
      vecs[12] = '{0, 1, 1, 2,  2'd2, 24'd1280, 10'd10, 10'd3};
      vecs[13] = '{1, 1, 1, 2,  2'd1, 24'd6400, 10'd11, 10'd3};

      reset_n       = 1'b0;
      read_request  = 1'b0;
      write_request = 1'b0;
      frame_restart = 1'b0;
      mem_busy      = 1'b0;
      repeat (3) @(negedge system_clock);
      check("reset_outputs", 32'({read_done, write_done, mem_output_size, mem_input_size,
                                  owner, timeout_error}), 32'd0);
      check("reset_addr", 32'(mem_output_address | mem_input_address), 32'd0);
      check("reset_lines", 32'({read_line, write_line}), 32'd0);
      reset_n = 1'b1;
      @(negedge system_clock);

      // Single reads, then both requesters competing under the starvation guard
      foreach (vecs[i]) begin
         read_request  = vecs[i].rd;
         write_request = vecs[i].wr;
         exp_q.push_back({vecs[i].own, vecs[i].addr});
         run_txn(vecs[i].dly, vecs[i].len, 1'b0);
         check("table_read_line", 32'(read_line), 32'(vecs[i].rl));
         check("table_write_line", 32'(write_line), 32'(vecs[i].wl));
      end
      read_request  = 1'b0;
      write_request = 1'b0;
      repeat (2) @(negedge system_clock);
      check("idle_no_grant", 32'(owner), 32'd0);

      // Restart in IDLE, then a full frame of reads through the wrap
      frame_restart = 1'b1;
      @(negedge system_clock);
      frame_restart = 1'b0;
      check("idle_restart_line", 32'(read_line), 32'd0);
      read_request = 1'b1;
      for (int k = 0; k < 480; k++) begin
         ea = 24'(k * 640);
         exp_q.push_back({2'd1, ea});
         run_txn($urandom_range(0, 1), 1, 1'b0);
      end
      check("wrap_read_line", 32'(read_line), 32'd0);
      exp_q.push_back({2'd1, 24'd0});
      run_txn(0, 1, 1'b0);

      // frame_restart during WAIT_READ at line 37
      for (int k = 1; k < 37; k++) begin
         ea = 24'(k * 640);
         exp_q.push_back({2'd1, ea});
         run_txn(0, $urandom_range(1, 2), 1'b0);
      end
      check("line_before_restart", 32'(read_line), 32'd37);
      exp_q.push_back({2'd1, 24'd23680});
      run_txn(1, 4, 1'b1);
      check("restart_read_line", 32'(read_line), 32'd0);
      check("restart_write_line", 32'(write_line), 32'd3);
      exp_q.push_back({2'd1, 24'd0});
      run_txn(0, 1, 1'b0);
      read_request = 1'b0;
      @(negedge system_clock);

      // Busy never rises after a write grant
      write_request = 1'b1;
      cnt = 0;
      while (owner == 2'd0 && cnt < 100) begin
         @(negedge system_clock);
         cnt++;
      end
      check("to_owner", 32'(owner), 32'd2);
      check("to_addr", 32'(mem_input_address), 32'd1920);
      cnt   = 1;
      wdone = 0;
      while (mem_input_size != 12'd0 && cnt < 5000) begin
         @(negedge system_clock);
         if (write_done) wdone++;
         if (mem_input_size != 12'd0) cnt++;
      end
      check("to_cycles", 32'(cnt), 32'd4095);
      check("to_size", 32'(mem_input_size), 32'd0);
      check("to_error", 32'(timeout_error), 32'd1);
      check("to_owner_idle", 32'(owner), 32'd0);
      check("to_no_done", 32'(wdone), 32'd0);
      check("to_write_line", 32'(write_line), 32'd3);
      exp_q.push_back({2'd2, 24'd1920});
      run_txn(1, 2, 1'b0);
      check("reissue_write_line", 32'(write_line), 32'd4);
      check("error_sticky", 32'(timeout_error), 32'd1);

      // Asynchronous reset in WAIT_WRITE
      cnt = 0;
      while (owner == 2'd0 && cnt < 100) begin
         @(negedge system_clock);
         cnt++;
      end
      check("rst_grant_addr", 32'(mem_input_address), 32'd2560);
      mem_busy = 1'b1;
      @(negedge system_clock);
      check("rst_in_wait", 32'(owner), 32'd2);
      #2 reset_n = 1'b0;
      #1;
      check("async_reset_outputs", 32'({read_done, write_done, mem_output_size, mem_input_size,
                                        owner, timeout_error}), 32'd0);
      check("async_reset_addr", 32'(mem_output_address | mem_input_address), 32'd0);
      check("async_reset_lines", 32'({read_line, write_line}), 32'd0);
      mem_busy      = 1'b0;
      write_request = 1'b0;
      @(negedge system_clock);
      reset_n = 1'b1;
      @(negedge system_clock);
      write_request = 1'b1;
      exp_q.push_back({2'd2, 24'd0});
      run_txn(1, 2, 1'b0);
      write_request = 1'b0;
      check("post_reset_write_line", 32'(write_line), 32'd1);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
